// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: loader FSM states,
// the fill word returned for masked fetches, and the word-index width helper.
package imem_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_LOAD = 2'd1,
    IMEM_DONE = 2'd2,
    IMEM_ERR  = 2'd3
  } imem_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_fsm.sv
// Byte-serial program loader: assembles little-endian bytes into words and
// generates memory write strobes; flags overflow past DEPTH words.
module imem_loader_fsm #(
  parameter int DEPTH = 1024,
  localparam int IDX_W = imem_pkg::idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             loading,
  output logic             load_done,
  output logic             ld_err,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr,
  output logic [31:0]      wr_data
);
  import imem_pkg::*;

  imem_state_t state, state_nxt;
  logic [IDX_W:0] ptr, ptr_nxt;
  logic [1:0]     cnt, cnt_nxt;
  logic [23:0]    asm_buf, asm_buf_nxt;
  logic [31:0]    word;
  logic           hs;
  logic           full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IMEM_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      asm_buf <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      asm_buf <= asm_buf_nxt;
    end
  end

  always_comb begin
    hs          = ld_valid && (state == IMEM_LOAD);
    full        = (ptr == (IDX_W+1)'(DEPTH));
    // Unfilled upper lanes stay zero because the buffer is cleared per word.
    word        = {8'h00, asm_buf};
    word[{cnt, 3'b000} +: 8] = ld_byte;
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    asm_buf_nxt = asm_buf;
    wr_en       = 1'b0;
    case (state)
      IMEM_LOAD: begin
        if (hs) begin
          if (full) begin
            state_nxt = IMEM_ERR;
          end else begin
            if (cnt == 2'd3 || ld_last) begin
              wr_en       = 1'b1;
              ptr_nxt     = ptr + 1'b1;
              cnt_nxt     = '0;
              asm_buf_nxt = '0;
            end else begin
              asm_buf_nxt = word[23:0];
              cnt_nxt     = cnt + 2'd1;
            end
            if (ld_last) state_nxt = IMEM_DONE;
          end
        end
      end
      default: begin
        if (ld_start) begin
          state_nxt   = IMEM_LOAD;
          ptr_nxt     = '0;
          cnt_nxt     = '0;
          asm_buf_nxt = '0;
        end
      end
    endcase
  end

  assign wr_addr   = ptr[IDX_W-1:0];
  assign wr_data   = word;
  assign ld_ready  = (state == IMEM_LOAD);
  assign loading   = (state == IMEM_LOAD);
  assign load_done = (state == IMEM_DONE);
  assign ld_err    = (state == IMEM_ERR);

endmodule

// File: rtl/imem_responder.sv
// Instruction memory for the single-cycle core: combinational fetch port plus
// byte loader that populates the array after reset.
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] NOP_WORD  = imem_pkg::NOP_WORD,
  parameter string       INIT_FILE = "imem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i_n,
  input  logic [31:0] i_addr,
  output logic [31:0] instr_read,
  output logic        i_misalign,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        loading,
  output logic        load_done,
  output logic        ld_err
);
  import imem_pkg::*;

  localparam int IDX_W = idx_w(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [31:0]      wr_data;
  logic             in_range;

  imem_loader_fsm #(.DEPTH(DEPTH)) u_loader (
    .clk       (clk),
    .rst       (rst),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .loading   (loading),
    .load_done (load_done),
    .ld_err    (ld_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign in_range   = ({2'b00, i_addr[31:2]} < 32'(DEPTH));
  assign i_misalign = (|i_addr[1:0]) & ~cs_i_n;

  always_comb begin
    if (cs_i_n)        instr_read = '0;
    else if (loading)  instr_read = NOP_WORD;
    else if (!in_range) instr_read = NOP_WORD;
    else               instr_read = mem[i_addr[IDX_W+1:2]];
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder (DEPTH=4) against a
// byte-stream image model of the loader and fetch port.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs_i_n = 1'b1;
  logic [31:0] i_addr = '0;
  logic [31:0] instr_read;
  logic        i_misalign;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready, loading, load_done, ld_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  logic [7:0]  stim [64];

  imem_responder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_i_n     (cs_i_n),
    .i_addr     (i_addr),
    .instr_read (instr_read),
    .i_misalign (i_misalign),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .loading    (loading),
    .load_done  (load_done),
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  // Streams stim[0..n-1] into the loader; optional ld_start re-pulse before
  // byte start_at and reset assertion right after byte abort_after.
  task automatic do_load(input int n, input bit last_final, input int abort_after,
                         input int start_at, input string tag);
    logic [31:0] pend;
    bit          is_last;
    int          gap;
    pend = '0;
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    cs_i_n = 1'b0;
    i_addr = 32'h4;
    #1;
    checks++;
    if (loading !== 1'b1 || ld_ready !== 1'b1 || load_done !== 1'b0 || ld_err !== 1'b0 ||
        instr_read !== NOP_WORD) begin
      errors++;
      $display("FAIL %s_start: loading=%b ld_ready=%b done=%b err=%b instr=%h, want 1 1 0 0 %h",
               tag, loading, ld_ready, load_done, ld_err, instr_read, NOP_WORD);
    end
    for (int k = 0; k < n; k++) begin
      if (k == start_at) begin
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        cs_i_n = 1'b0;
        i_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        #1;
        checks++;
        if (instr_read !== NOP_WORD) begin
          errors++;
          $display("FAIL %s_fetch_during_load: addr=%h instr=%h, want %h",
                   tag, i_addr, instr_read, NOP_WORD);
        end
        @(negedge clk);
      end
      is_last  = last_final && (k == n - 1);
      ld_valid = 1'b1;
      ld_byte  = stim[k];
      ld_last  = is_last;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (k >= 4 * DEPTH) begin
        checks++;
        if (ld_err !== 1'b1 || loading !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0) begin
          errors++;
          $display("FAIL %s_overflow: err=%b loading=%b ready=%b done=%b, want 1 0 0 0",
                   tag, ld_err, loading, ld_ready, load_done);
        end
        return;
      end
      pend[8*(k%4) +: 8] = stim[k];
      if ((k % 4) == 3 || is_last) begin
        model_mem[k/4] = pend;
        model_vld[k/4] = 1'b1;
        pend = '0;
      end
      if (is_last) begin
        checks++;
        if (load_done !== 1'b1 || loading !== 1'b0 || ld_err !== 1'b0) begin
          errors++;
          $display("FAIL %s_done: done=%b loading=%b err=%b, want 1 0 0",
                   tag, load_done, loading, ld_err);
        end
        return;
      end
      checks++;
      if (loading !== 1'b1) begin
        errors++;
        $display("FAIL %s_loading_byte%0d: loading=%b, want 1", tag, k, loading);
      end
      if (k == abort_after) begin
        rst = 1'b0;
        #1;
        checks++;
        if (loading !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0 || ld_err !== 1'b0) begin
          errors++;
          $display("FAIL %s_async_reset: loading=%b ready=%b done=%b err=%b, want 0 0 0 0",
                   tag, loading, ld_ready, load_done, ld_err);
        end
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ld_ready !== 1'b0 || loading !== 1'b0 || load_done !== 1'b0 || ld_err !== 1'b0 ||
        instr_read !== 32'h0 || i_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b loading=%b done=%b err=%b instr=%h mis=%b, want all 0",
               ld_ready, loading, load_done, ld_err, instr_read, i_misalign);
    end
    // ld_valid while idle must be ignored.
    @(negedge clk);
    rst = 1'b1;
    ld_valid = 1'b1;
    ld_byte = 8'hAA;
    @(negedge clk);
    ld_valid = 1'b0;
    checks++;
    if (loading !== 1'b0 || ld_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: loading=%b ready=%b done=%b, want 0 0 0",
               loading, ld_ready, load_done);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] img [6] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    for (int i = 0; i < 6; i++) stim[i] = img[i];
    do_load(6, 1'b1, -1, -1, "basic");
    cs_i_n = 1'b0;
    i_addr = 32'h0;
    #1;
    checks++;
    if (instr_read !== 32'h0050_0093) begin
      errors++;
      $display("FAIL basic_word0: instr=%h, want 00500093", instr_read);
    end
    i_addr = 32'h6;
    #1;
    checks++;
    if (instr_read !== 32'h0000_0113 || i_misalign !== 1'b1) begin
      errors++;
      $display("FAIL basic_word1_misalign: instr=%h mis=%b, want 00000113 1", instr_read, i_misalign);
    end
    cs_i_n = 1'b1;
    #1;
    checks++;
    if (instr_read !== 32'h0 || i_misalign !== 1'b0) begin
      errors++;
      $display("FAIL deselect: instr=%h mis=%b, want 0 0", instr_read, i_misalign);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) stim[i] = 8'($urandom);
    do_load(17, 1'b1, -1, -1, "overflow");
    cs_i_n = 1'b0;
    i_addr = 32'h10;
    #1;
    checks++;
    if (instr_read !== NOP_WORD) begin
      errors++;
      $display("FAIL overflow_fetch_0x10: instr=%h, want %h", instr_read, NOP_WORD);
    end
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 4 * DEPTH);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      do_load(n, 1'b1, -1, -1, "random");
      test_fetch("random");
    end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    do_load(12, 1'b1, -1, 6, "restart");
    test_fetch("restart");
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] old1;
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    do_load(16, 1'b1, -1, -1, "preload");
    old1 = model_mem[1];
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    do_load(12, 1'b1, 5, -1, "midreset");
    @(negedge clk);
    cs_i_n = 1'b0;
    i_addr = 32'h0;
    #1;
    checks++;
    if (instr_read !== {stim[3], stim[2], stim[1], stim[0]}) begin
      errors++;
      $display("FAIL midreset_word0: instr=%h, want %h", instr_read,
               {stim[3], stim[2], stim[1], stim[0]});
    end
    i_addr = 32'h4;
    #1;
    checks++;
    if (instr_read !== old1) begin
      errors++;
      $display("FAIL midreset_word1: instr=%h, want %h", instr_read, old1);
    end
  endtask

  task automatic test_fetch(input string tag);
    for (int i = 0; i < 12; i++) begin
      logic        cs;
      logic [31:0] a;
      logic [31:0] exp_i;
      bit          known;
      int          w;
      @(negedge clk);
      cs = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) a = $urandom | 32'h8000_0000;
      else a = 32'($urandom_range(0, DEPTH * 4 + 11));
      cs_i_n = cs;
      i_addr = a;
      #1;
      w = int'(a[31:2]);
      known = 1'b1;
      if (cs) exp_i = 32'h0;
      else if (w >= DEPTH) exp_i = NOP_WORD;
      else begin
        exp_i = model_mem[w];
        known = model_vld[w];
      end
      checks++;
      if (i_misalign !== ((|a[1:0]) & ~cs)) begin
        errors++;
        $display("FAIL %s_misalign: addr=%h cs_n=%b mis=%b, want %b",
                 tag, a, cs, i_misalign, (|a[1:0]) & ~cs);
      end
      if (known) begin
        checks++;
        if (instr_read !== exp_i) begin
          errors++;
          $display("FAIL %s_fetch: addr=%h cs_n=%b instr=%h, want %h",
                   tag, a, cs, instr_read, exp_i);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_vld[i] = 1'b0;
    end
    test_reset();
    test_basic_load();
    test_fetch("basic");
    test_overflow();
    test_fetch("overflow");
    test_random_loads();
    test_restart_ignored();
    test_reset_mid_load();
    test_fetch("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
